uart_rx: RTL and testbench
==========================

# uart_rx

UART receive path, the companion to the existing transmitter: recovers 8-bit frames (start bit, 8 data bits LSB first, optional parity, 1 stop bit) from the asynchronous serial line `rxd`. It samples the line on an oversampling tick supplied by the shared baud generator. Each received byte is presented with a one-cycle valid pulse and per-frame parity and framing error flags to the host-side logic (FIFO or register bank).

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit period. Must be even and ≥ 4.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high; overrides every other input.
- `sample_tick` input 1: one-`clk` pulse at OVERSAMPLE × baud rate; the FSM advances only on cycles where it is 1.
- `rxd` input 1: asynchronous serial input; idles high.
- `parity_en` input 1: 1 means a parity bit follows the data bits.
- `parity_type` input 1: 0 is even parity, 1 is odd (same encoding as the transmitter).
- `rx_data` output 8: last received byte.
- `rx_valid` output 1: one-`clk` pulse when a frame completes.
- `parity_err` output 1: parity mismatch in the last frame.
- `frame_err` output 1: stop bit was sampled low in the last frame.
- `rx_busy` output 1: high from start-bit confirmation until the frame completes.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer (reset value 1) before use, giving `rxd_s`. This adds 2 `clk` of latency.
- **Counters:** `tick_cnt` is `$clog2(OVERSAMPLE)` bits wide and `bit_idx` is 3 bits wide. Both update only on `sample_tick`.
- **States** (3-bit encoding): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - **IDLE:** when `rxd_s`=0 on a tick, clear `tick_cnt`, latch `parity_en`/`parity_type`, and go to START. These configuration inputs are ignored mid-frame.
  - **START:**
    - Count ticks. When `tick_cnt`=OVERSAMPLE/2−1 (mid start bit), re-check the line.
    - If `rxd_s`=1, it is a false start: return to IDLE; `rx_busy` never asserts.
    - Otherwise set `rx_busy`=1, clear `tick_cnt` and `bit_idx`, and go to DATA.
  - **DATA:**
    - Sample one bit every OVERSAMPLE ticks, i.e. at each bit centre. The sample is shifted into the MSB of the shift register, so after 8 bits the LSB is the first bit received.
    - After `bit_idx`=7, go to PARITY if the latched `parity_en` is 1, else to STOP. Otherwise increment `bit_idx`.
  - **PARITY:**
    - At the bit centre, compute `perr` as follows. With even parity, `perr` = sampled bit XOR (^data). With odd parity, `perr` = sampled bit XOR ~(^data).
    - Go to STOP.
  - **STOP:**
    - At the bit centre, sample the stop bit.
    - On that same `clk`, update `rx_data`, set `parity_err` (0 when parity is disabled), set `frame_err` to the inverse of the sampled stop bit, pulse `rx_valid`, and clear `rx_busy`.
    - If the stop bit was 1, go to IDLE.
    - If the stop bit was 0 (break or framing error), stay in STOP until `rxd_s`=1 is seen on a tick, then go to IDLE. A held-low line therefore yields exactly one `rx_valid`.
- **Output hold:** `rx_data`, `parity_err` and `frame_err` hold their values until the next `rx_valid`. A frame with errors still delivers its data and a `rx_valid` pulse.
- **Reset:** all outputs are 0, the synchronizer flops are 1, and the state is IDLE. A reset in mid-frame discards the partial frame with no `rx_valid`. Reception resumes at the next falling edge.

## Timing
- Start detection to the start-bit centre takes OVERSAMPLE/2 ticks. Each further bit centre is OVERSAMPLE ticks after the previous one.
- `rx_valid` asserts on the `clk` of the stop-bit-centre tick: 9.5 (no parity) or 10.5 (with parity) bit periods after the falling edge at `rxd_s`, plus 2 `clk` of synchronizer delay.
- The receiver accepts back-to-back frames. IDLE is re-entered at the stop-bit centre, so a start edge arriving half a bit later is detected.
- If `sample_tick` stays low, all state freezes; `rx_valid` is never asserted without a tick.

## Structure
- **Shared package `uart_pkg`:** holds the state encodings (shared with the transmitter's IDLE/START/DATA/PARITY/STOP values) and the constants PARITY_EVEN=0 and PARITY_ODD=1.
- **Sub-module `uart_sync2`:** the 2-flop synchronizer, with a parameterised reset value. It is reusable for other asynchronous inputs.
- **Top module `uart_rx`:** contains the FSM, counters, shift register and error logic (about 150–200 lines).

## Test plan
All scenarios use OVERSAMPLE=16, `sample_tick` every 4th `clk`, and serial stimulus driven by a bench bit-banger or by the existing transmitter in loopback.

- **No parity:** send 0xA5 → one `rx_valid`; `rx_data`=0xA5, `parity_err`=0, `frame_err`=0; `rx_busy` high for exactly the frame duration.
- **Parity:** even parity, send 0x03 with parity bit 0 → `parity_err`=0. Same byte with parity bit 1 → `parity_err`=1, `rx_data`=0x03. Odd parity, 0x03 with parity bit 1 → `parity_err`=0.
- **False start and glitch:** a 4-tick low glitch on `rxd` → no `rx_valid`, `rx_busy` stays 0, state returns to IDLE.
- **Framing error:** send 0x55 with stop bit 0, then hold the line low 3 bit periods → exactly one `rx_valid` with `frame_err`=1; a following 0x3C is then received cleanly with `frame_err`=0.
- **Back-to-back loopback:** transmitter to receiver with 0x00, 0xFF, 0x81 at zero idle gap → three `rx_valid` pulses with matching data and no errors.
- **Reset mid-frame:** assert `reset` for 1 `clk` during data bit 4 → all outputs 0, no `rx_valid`; the next full frame of 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings (common to the TX and RX
// paths) and parity-type constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so it can sit on idle-high or idle-low lines.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages load the idle level on reset so no false edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit qualification, 8 data bits LSB first,
// optional parity, one stop bit. Delivers each byte with a one-cycle valid
// pulse plus per-frame parity and framing error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  logic rxd_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  uart_state_t   state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_en_q, par_en_d;
  logic          par_type_q, par_type_d;
  logic          perr_q, perr_d;
  logic          brk_q, brk_d;
  logic [7:0]    rx_data_d;
  logic          rx_valid_d, parity_err_d, frame_err_d, rx_busy_d;

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      perr_q     <= 1'b0;
      brk_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      perr_q     <= perr_d;
      brk_q      <= brk_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      rx_busy    <= rx_busy_d;
    end
  end

  // Next-state and output logic; everything holds unless a sample tick arrives.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    perr_d       = perr_q;
    brk_d        = brk_q;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    rx_busy_d    = rx_busy;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            tick_cnt_d = '0;
            par_en_d   = parity_en;
            par_type_d = parity_type;
            state_d    = START;
          end
        end

        START: begin
          if (tick_cnt_q == HALF_M1) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              rx_busy_d  = 1'b1;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
              state_d    = DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shreg_d    = {rxd_s, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            perr_d     = rxd_s ^ (^shreg_q) ^ (par_type_q == PARITY_ODD);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        STOP: begin
          // brk_q marks a low stop bit already reported; wait for the line to
          // return high so a held break produces only one valid pulse.
          if (brk_q) begin
            if (rxd_s) begin
              brk_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d   = '0;
            rx_data_d    = shreg_q;
            parity_err_d = par_en_q & perr_q;
            frame_err_d  = ~rxd_s;
            rx_valid_d   = 1'b1;
            rx_busy_d    = 1'b0;
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              brk_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged serial frames, a frame-level
// expectation queue with latency and busy-width rules, and literal checks.
module tb_uart_rx;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLK  = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, rx_busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rxd         (rxd),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      sample_tick = ((cyc % TICK_DIV) == 0);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        par;
    int unsigned t0;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      me;
  logic [7:0]  exp_data = '0;
  logic        exp_perr = 1'b0;
  logic        exp_ferr = 1'b0;
  int unsigned valid_cnt = 0;
  int unsigned busy_cycles = 0;
  int unsigned run = 0;
  logic        prev_busy = 1'b0;

  // Compare process: outputs must always equal the last delivered frame.
  always @(negedge clk) begin
    if (reset) begin
      exp_data  = '0;
      exp_perr  = 1'b0;
      exp_ferr  = 1'b0;
      exp_q.delete();
      run       = 0;
      prev_busy = 1'b0;
    end else begin
      check("busy_drop_without_valid", prev_busy && !rx_busy && !rx_valid, 1'b0);
      if (rx_valid) begin
        valid_cnt++;
        check("valid_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          me       = exp_q.pop_front();
          exp_data = me.data;
          exp_perr = me.perr;
          exp_ferr = me.ferr;
          check("busy_len", run, me.par ? 10 * BIT_CLK : 9 * BIT_CLK);
          check_range("latency", cyc - me.t0,
                      3 + (me.par ? 21 : 19) * BIT_CLK / 2,
                      6 + (me.par ? 21 : 19) * BIT_CLK / 2);
        end
      end
      check("rx_data", rx_data, exp_data);
      check("parity_err", parity_err, exp_perr);
      check("frame_err", frame_err, exp_ferr);
      if (rx_busy) begin
        run++;
        busy_cycles++;
      end else begin
        run = 0;
      end
      prev_busy = rx_busy;
    end
  end

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one full frame; the expectation is queued before the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stop_bit, input logic scramble);
    frame_t e;
    int unsigned ones;
    parity_en   = pen;
    parity_type = ptype;
    rxd  = 1'b0;
    e.t0 = cyc;
    wait_clks(BIT_CLK);
    if (scramble) begin
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clks(BIT_CLK);
    end
    if (pen) begin
      rxd = pbit;
      wait_clks(BIT_CLK);
    end
    ones   = $countones(d) + (pbit ? 1 : 0);
    e.data = d;
    e.par  = pen;
    e.ferr = ~stop_bit;
    e.perr = pen ? (ptype ? (ones % 2 == 0) : (ones % 2 == 1)) : 1'b0;
    exp_q.push_back(e);
    rxd = stop_bit;
    wait_clks(BIT_CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  int unsigned v0, b0;
  logic [7:0]  rd, vbyte;
  logic        rpen, rptype, rpbit, rstop;

  initial begin
    wait_clks(6);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    reset = 1'b0;
    wait_clks(3 * BIT_CLK);

    // No parity
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check("a5_count", valid_cnt - v0, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);

    // Parity cases
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_clks(BIT_CLK);
    check("even_ok_perr", parity_err, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_clks(BIT_CLK);
    check("even_bad_perr", parity_err, 1'b1);
    check("even_bad_data", rx_data, 8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_clks(BIT_CLK);
    check("odd_ok_perr", parity_err, 1'b0);

    // 4-tick glitch
    v0 = valid_cnt;
    b0 = busy_cycles;
    rxd = 1'b0;
    wait_clks(4 * TICK_DIV);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLK);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_busy", busy_cycles - b0, 0);

    // Framing error with held-low line, then clean frame
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rxd = 1'b0;
    wait_clks(3 * BIT_CLK);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLK);
    check("break_count", valid_cnt - v0, 1);
    check("break_ferr", frame_err, 1'b1);
    check("break_data", rx_data, 8'h55);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check("after_break_data", rx_data, 8'h3C);
    check("after_break_ferr", frame_err, 1'b0);

    // Back-to-back, zero idle gap
    v0 = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check("b2b_count", valid_cnt - v0, 3);
    check("b2b_last", rx_data, 8'h81);

    // Reset during data bit 4
    v0 = valid_cnt;
    vbyte = 8'h5A;
    parity_en = 1'b0;
    rxd = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rxd = vbyte[i];
      wait_clks(BIT_CLK);
    end
    rxd = vbyte[4];
    wait_clks(BIT_CLK / 2);
    check("pre_reset_busy", rx_busy, 1'b1);
    reset = 1'b1;
    rxd   = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    check("mid_reset_data", rx_data, 8'h00);
    check("mid_reset_valid", rx_valid, 1'b0);
    check("mid_reset_busy", rx_busy, 1'b0);
    check("mid_reset_ferr", frame_err, 1'b0);
    wait_clks(2 * BIT_CLK);
    check("mid_reset_count", valid_cnt - v0, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(BIT_CLK);
    check("post_reset_data", rx_data, 8'h5A);

    // Randomized frames against the expectation queue
    v0 = valid_cnt;
    for (int n = 0; n < 40; n++) begin
      rd     = 8'($urandom);
      rpen   = 1'($urandom);
      rptype = 1'($urandom);
      rpbit  = rptype ? ~(^rd) : (^rd);
      if ($urandom_range(0, 3) == 0) rpbit = ~rpbit;
      rstop  = ($urandom_range(0, 5) != 0);
      send_frame(rd, rpen, rptype, rpbit, rstop, 1'b1);
      rxd = 1'b1;
      if (!rstop) begin
        wait_clks(BIT_CLK + $urandom_range(0, 40));
      end else if ($urandom_range(0, 2) != 0) begin
        wait_clks($urandom_range(1, 100));
      end
    end
    wait_clks(2 * BIT_CLK);
    check("random_count", valid_cnt - v0, 40);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
